ppt_match_ctrl: RTL and testbench

- Sequences a full rock-paper-scissors match between two players.
- Collects one move per player per round over valid/ready handshakes, judges the round, keeps the scores, and declares the match winner once a player reaches WINS_NEEDED round wins.
- Ties replay the round. A timeout awards the round to the only player who submitted.
- Sits between player input logic and the scoreboard/display logic.

---
 rtl/ppt_pkg.sv | 21 ++
 rtl/ppt_match_ctrl_if.sv | 21 ++
 rtl/ppt_judge.sv | 22 ++
 rtl/ppt_match_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ppt_match_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ppt_pkg.sv
// rtl/ppt_pkg.sv - shared move/result encodings and controller state type
package ppt_pkg;

  localparam logic [1:0] MV_INVALID  = 2'b00;
  localparam logic [1:0] MV_ROCK     = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_J2  = 2'b01;
  localparam logic [1:0] RES_J1  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    JUDGE,
    REPORT,
    DONE
  } state_t;

endpackage

// File: rtl/ppt_match_ctrl_if.sv
// rtl/ppt_match_ctrl_if.sv - player move handshakes for both players
interface ppt_match_ctrl_if;

  logic [1:0] j1_move;
  logic       j1_valid;
  logic       j1_ready;
  logic [1:0] j2_move;
  logic       j2_valid;
  logic       j2_ready;

  modport master (
    output j1_move, j1_valid, j2_move, j2_valid,
    input  j1_ready, j2_ready
  );

  modport slave (
    input  j1_move, j1_valid, j2_move, j2_valid,
    output j1_ready, j2_ready
  );

endinterface

// File: rtl/ppt_judge.sv
// rtl/ppt_judge.sv - combinational round judge, {j1_w,j2_w}
module ppt_judge
  import ppt_pkg::*;
(
  input  logic [1:0] j1_move,
  input  logic [1:0] j2_move,
  output logic [1:0] result
);

  always_comb begin
    result = RES_TIE;
    if (j1_move != MV_INVALID && j2_move != MV_INVALID && j1_move != j2_move) begin
      case ({j1_move, j2_move})
        {MV_PAPER, MV_ROCK},
        {MV_ROCK, MV_SCISSORS},
        {MV_SCISSORS, MV_PAPER}: result = RES_J1;
        default:                 result = RES_J2;
      endcase
    end
  end

endmodule

// File: rtl/ppt_match_ctrl.sv
// rtl/ppt_match_ctrl.sv - rock-paper-scissors match sequencer
module ppt_match_ctrl
  import ppt_pkg::*;
#(
  parameter int WINS_NEEDED    = 2,
  parameter int SCORE_W        = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  ppt_match_ctrl_if.slave    plyr,
  input  logic               start,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic               round_timeout,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               busy,
  output logic               err_invalid
);

  localparam logic [SCORE_W-1:0] WINS_L = SCORE_W'(WINS_NEEDED);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [1:0]         j1_mv_q, j1_mv_d;
  logic [1:0]         j2_mv_q, j2_mv_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [1:0]         round_result_q, round_result_d;
  logic               round_timeout_q, round_timeout_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [1:0]         match_winner_q, match_winner_d;
  logic               err_q, err_d;

  logic       j1_rdy, j2_rdy;
  logic       hs1, hs2, acc1, acc2;
  logic       held1, held2, have1_n, have2_n;
  logic [1:0] judge_res;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  ppt_judge u_judge (
    .j1_move (j1_mv_q),
    .j2_move (j2_mv_q),
    .result  (judge_res)
  );

  // A latched move is never 00, so a non-zero latch doubles as the "held" flag.
  assign held1   = (j1_mv_q != MV_INVALID);
  assign held2   = (j2_mv_q != MV_INVALID);
  assign j1_rdy  = (state_q == COLLECT) && !held1;
  assign j2_rdy  = (state_q == COLLECT) && !held2;
  assign hs1     = plyr.j1_valid && j1_rdy;
  assign hs2     = plyr.j2_valid && j2_rdy;
  assign acc1    = hs1 && (plyr.j1_move != MV_INVALID);
  assign acc2    = hs2 && (plyr.j2_move != MV_INVALID);
  assign have1_n = held1 || acc1;
  assign have2_n = held2 || acc2;

  always_comb begin
    state_d         = state_q;
    j1_mv_d         = j1_mv_q;
    j2_mv_d         = j2_mv_q;
    to_cnt_d        = to_cnt_q;
    round_result_d  = round_result_q;
    round_timeout_d = round_timeout_q;
    score1_d        = score1_q;
    score2_d        = score2_q;
    match_winner_d  = match_winner_q;
    err_d           = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = COLLECT;
          score1_d       = '0;
          score2_d       = '0;
          match_winner_d = RES_TIE;
        end
      end

      COLLECT: begin
        err_d = (hs1 && !acc1) || (hs2 && !acc2);
        if (acc1) j1_mv_d = plyr.j1_move;
        if (acc2) j2_mv_d = plyr.j2_move;
        if (have1_n && have2_n) begin
          state_d = JUDGE;
        end else if (held1 || held2) begin
          // The missing move did not arrive this cycle; a handshake on the last
          // counter cycle is caught by the branch above and wins over timeout.
          if (to_cnt_q == TO_LAST) begin
            state_d         = REPORT;
            round_timeout_d = 1'b1;
            if (held1) begin
              round_result_d = RES_J1;
              score1_d       = sat_inc(score1_q);
            end else begin
              round_result_d = RES_J2;
              score2_d       = sat_inc(score2_q);
            end
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else if (have1_n || have2_n) begin
          to_cnt_d = '0;
        end
      end

      JUDGE: begin
        state_d         = REPORT;
        round_result_d  = judge_res;
        round_timeout_d = 1'b0;
        if (judge_res == RES_J1) score1_d = sat_inc(score1_q);
        if (judge_res == RES_J2) score2_d = sat_inc(score2_q);
      end

      REPORT: begin
        j1_mv_d  = MV_INVALID;
        j2_mv_d  = MV_INVALID;
        to_cnt_d = '0;
        if (score1_q == WINS_L) begin
          state_d        = DONE;
          match_winner_d = RES_J1;
        end else if (score2_q == WINS_L) begin
          state_d        = DONE;
          match_winner_d = RES_J2;
        end else begin
          state_d = COLLECT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      j1_mv_q         <= MV_INVALID;
      j2_mv_q         <= MV_INVALID;
      to_cnt_q        <= '0;
      round_result_q  <= RES_TIE;
      round_timeout_q <= 1'b0;
      score1_q        <= '0;
      score2_q        <= '0;
      match_winner_q  <= RES_TIE;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      j1_mv_q         <= j1_mv_d;
      j2_mv_q         <= j2_mv_d;
      to_cnt_q        <= to_cnt_d;
      round_result_q  <= round_result_d;
      round_timeout_q <= round_timeout_d;
      score1_q        <= score1_d;
      score2_q        <= score2_d;
      match_winner_q  <= match_winner_d;
      err_q           <= err_d;
    end
  end

  assign plyr.j1_ready = j1_rdy;
  assign plyr.j2_ready = j2_rdy;
  assign round_done    = (state_q == REPORT);
  assign round_result  = round_result_q;
  assign round_timeout = round_timeout_q;
  assign score1        = score1_q;
  assign score2        = score2_q;
  assign match_done    = (state_q == DONE);
  assign match_winner  = match_winner_q;
  assign busy          = (state_q == COLLECT) || (state_q == JUDGE) || (state_q == REPORT);
  assign err_invalid   = err_q;

endmodule

// File: tb/tb_ppt_match_ctrl.sv
// tb/tb_ppt_match_ctrl.sv - directed self-checking bench for ppt_match_ctrl
module tb_ppt_match_ctrl;

  localparam logic [1:0] INV = 2'b00;
  localparam logic [1:0] RCK = 2'b01;
  localparam logic [1:0] PAP = 2'b10;
  localparam logic [1:0] SCI = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       round_done;
  logic [1:0] round_result;
  logic       round_timeout;
  logic [1:0] score1;
  logic [1:0] score2;
  logic       match_done;
  logic [1:0] match_winner;
  logic       busy;
  logic       err_invalid;

  int n_checks = 0;
  int n_fail   = 0;

  ppt_match_ctrl_if pif ();

  ppt_match_ctrl #(
    .WINS_NEEDED    (2),
    .SCORE_W        (2),
    .TIMEOUT_CYCLES (16),
    .TO_W           (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .plyr          (pif.slave),
    .start         (start),
    .round_done    (round_done),
    .round_result  (round_result),
    .round_timeout (round_timeout),
    .score1        (score1),
    .score2        (score2),
    .match_done    (match_done),
    .match_winner  (match_winner),
    .busy          (busy),
    .err_invalid   (err_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [1:0] m1, input logic v2, input logic [1:0] m2);
    pif.j1_valid = v1;
    pif.j1_move  = m1;
    pif.j2_valid = v2;
    pif.j2_move  = m2;
  endtask

  // Both moves in one cycle; returns in the round_done cycle.
  task automatic play(input logic [1:0] m1, input logic [1:0] m2);
    drive(1'b1, m1, 1'b1, m2);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive(1'b0, INV, 1'b0, INV);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_score1", score1, 0);
    check("rst_result", round_result, 0);
    check("rst_winner", match_winner, 0);
    check("rst_ready", {pif.j1_ready, pif.j2_ready}, 0);
    check("rst_done", {round_done, match_done}, 0);

    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", {pif.j1_ready, pif.j2_ready}, 2'b11);

    drive(1'b1, RCK, 1'b1, SCI);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    check("r1_judge_nodone", round_done, 0);
    check("r1_judge_ready", {pif.j1_ready, pif.j2_ready}, 0);
    tick();
    check("r1_done", round_done, 1);
    check("r1_result", round_result, 2'b10);
    check("r1_score1", score1, 1);
    check("r1_timeout", round_timeout, 0);
    check("r1_report_ready", {pif.j1_ready, pif.j2_ready}, 0);
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ign", busy, 1);
    check("busy_start_score", score1, 1);
    check("busy_start_ready", pif.j1_ready, 1);

    play(PAP, RCK);
    check("r2_done", round_done, 1);
    check("r2_score1", score1, 2);
    tick();
    check("m1_match_done", match_done, 1);
    check("m1_winner", match_winner, 2'b10);
    check("m1_busy", busy, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("m2_score1_clr", score1, 0);
    check("m2_winner_clr", match_winner, 0);
    check("m2_done_clr", match_done, 0);

    play(RCK, RCK);
    check("tie_result", round_result, 2'b00);
    check("tie_scores", {score1, score2}, 0);
    tick();
    check("tie_replay", pif.j1_ready, 1);

    play(SCI, RCK);
    check("p2_result", round_result, 2'b01);
    check("p2_score2", score2, 1);
    tick();

    drive(1'b1, PAP, 1'b0, INV);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    check("to_ready", {pif.j1_ready, pif.j2_ready}, 2'b01);
    repeat (15) tick();
    check("to_early", round_done, 0);
    check("to_wait_ready", pif.j2_ready, 1);
    tick();
    check("to_done", round_done, 1);
    check("to_result", round_result, 2'b10);
    check("to_flag", round_timeout, 1);
    check("to_score1", score1, 1);
    tick();

    drive(1'b1, RCK, 1'b0, INV);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    repeat (15) tick();
    check("late_ready", pif.j2_ready, 1);
    check("late_nodone", round_done, 0);
    drive(1'b0, INV, 1'b1, PAP);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    check("late_judge", {busy, round_done}, 2'b10);
    tick();
    check("late_done", round_done, 1);
    check("late_result", round_result, 2'b01);
    check("late_flag", round_timeout, 0);
    check("late_score2", score2, 2);
    tick();
    check("m2_match_done", match_done, 1);
    check("m2_winner", match_winner, 2'b01);

    start = 1'b1;
    tick();
    start = 1'b0;
    play(RCK, SCI);
    check("m3_score1", score1, 1);
    tick();

    drive(1'b1, INV, 1'b0, INV);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    check("inv_err", err_invalid, 1);
    check("inv_ready", pif.j1_ready, 1);
    check("inv_busy", busy, 1);
    tick();
    check("inv_err_pulse", err_invalid, 0);
    drive(1'b1, RCK, 1'b0, INV);
    tick();
    drive(1'b0, INV, 1'b0, INV);
    check("inv_then_legal", {pif.j1_ready, pif.j2_ready}, 2'b01);
    check("legal_no_err", err_invalid, 0);

    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_score1", score1, 0);
    check("mid_rst_result", round_result, 0);
    check("mid_rst_ready", {pif.j1_ready, pif.j2_ready}, 0);
    check("mid_rst_done", round_done, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
